// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch user-interface blocks.
// Synthesis defaults are sized for a real board clock; SIM_DEBOUNCE_CYCLES keeps benches short.
package stopwatch_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_CNT_W           = 20;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int SIM_DEBOUNCE_CYCLES = 4;

  typedef struct packed {
    logic pause;
    logic rst;
  } btn_evt_t;

  // A RESET event always wins and clears the pause level, even alongside a PAUSE press.
  function automatic logic next_pause(input logic cur, input btn_evt_t evt);
    logic nxt;
    if (evt.rst) begin
      nxt = 1'b0;
    end else if (evt.pause) begin
      nxt = ~cur;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One debounce channel: synchronizer chain, stability counter and accepted-value register.
// A W-bit vector shares one counter so the accepted value only ever moves as a whole.
module debounce_ch
  import stopwatch_pkg::*;
#(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync_r [SYNC_STAGES];
  logic [W-1:0]     sync_s;
  logic [W-1:0]     cand_r;
  logic [W-1:0]     stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] eff_cnt_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Plain flop chain; nothing combinational ahead of the last stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {W{1'b0}};
      end
    end else begin
      sync_r[0] <= raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // The count restarts whenever the synchronized value moves, so a skewed multi-bit
  // change is only accepted once every bit has been steady for the full window.
  always_comb begin
    eff_cnt_s = {CNT_W{1'b0}};
    if (sync_s == cand_r) begin
      eff_cnt_s = cnt_r;
    end else begin
      eff_cnt_s = {CNT_W{1'b0}};
    end
  end

  // Terminal compare comes before the increment, so the counter can never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_r   <= {W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      stable_r <= {W{1'b0}};
    end else begin
      cand_r <= sync_s;
      if (sync_s == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (eff_cnt_s == TERM_C) begin
        stable_r <= sync_s;
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= eff_cnt_s + CNT_W'(1'b1);
      end
    end
  end

  assign stable_o = stable_r;

endmodule

// File: rtl/input_conditioner.sv
// Inbound stopwatch UI conditioning: four debounce channels plus button edge detection,
// the pause toggle and RESET-over-PAUSE priority.
module input_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause_i,
  input  logic       btn_rst_i,
  input  logic       sw_adj_i,
  input  logic [1:0] sw_sel_i,
  output logic       pause_o,
  output logic       rst_pulse_o,
  output logic       adj_o,
  output logic [1:0] sel_o
);

  logic     pause_stable_s;
  logic     rst_stable_s;
  logic     pause_prev_r;
  logic     rst_prev_r;
  logic     pause_r;
  logic     rst_pulse_r;
  btn_evt_t evt_s;

  debounce_ch #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES))
    u_pause (.clk(clk), .rst(rst), .raw_i(btn_pause_i), .stable_o(pause_stable_s));

  debounce_ch #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES))
    u_rst (.clk(clk), .rst(rst), .raw_i(btn_rst_i), .stable_o(rst_stable_s));

  debounce_ch #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES))
    u_adj (.clk(clk), .rst(rst), .raw_i(sw_adj_i), .stable_o(adj_o));

  debounce_ch #(.W(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES))
    u_sel (.clk(clk), .rst(rst), .raw_i(sw_sel_i), .stable_o(sel_o));

  // A press is a rise of the debounced level; releases and long holds give no event.
  always_comb begin
    evt_s       = '{pause: 1'b0, rst: 1'b0};
    evt_s.pause = pause_stable_s & ~pause_prev_r;
    evt_s.rst   = rst_stable_s & ~rst_prev_r;
  end

  // Button outputs land one registered cycle after the debounced rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_prev_r <= 1'b0;
      rst_prev_r   <= 1'b0;
      pause_r      <= 1'b0;
      rst_pulse_r  <= 1'b0;
    end else begin
      pause_prev_r <= pause_stable_s;
      rst_prev_r   <= rst_stable_s;
      pause_r      <= next_pause(pause_r, evt_s);
      rst_pulse_r  <= evt_s.rst;
    end
  end

  assign pause_o     = pause_r;
  assign rst_pulse_o = rst_pulse_r;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues the expected output vector at a
// given cycle; a monitor compares on every scheduled cycle and on every output change.
module tb_input_conditioner;
  import stopwatch_pkg::*;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_pause_i;
  logic       btn_rst_i;
  logic       sw_adj_i;
  logic [1:0] sw_sel_i;
  logic       pause_o;
  logic       rst_pulse_o;
  logic       adj_o;
  logic [1:0] sel_o;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   t0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
    .CNT_W(DEF_CNT_W),
    .SYNC_STAGES(DEF_SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_pause_i(btn_pause_i), .btn_rst_i(btn_rst_i),
    .sw_adj_i(sw_adj_i), .sw_sel_i(sw_sel_i),
    .pause_o(pause_o), .rst_pulse_o(rst_pulse_o),
    .adj_o(adj_o), .sel_o(sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Expected vector layout: {pause, rst_pulse, adj, sel[1:0]}; kept sorted by cycle.
  task automatic push_exp(input int at, input logic p, input logic r, input logic a,
                          input logic [1:0] s, input string tag);
    exp_t e;
    int   i;
    e.cyc = at;
    e.v   = {p, r, a, s};
    e.tag = tag;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= at) i++;
    exp_q.insert(i, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scheduled checks, missed schedules, and any output change nobody expected.
  initial begin
    logic [4:0] outv;
    logic [4:0] prev;
    bit         matched;
    prev = 5'b00000;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        outv    = {pause_o, rst_pulse_o, adj_o, sel_o};
        matched = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: cycle %0d never checked (now %0d)", exp_q[0].tag, exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          n_tests++;
          matched = 1'b1;
          if (outv !== exp_q[0].v) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got {p,r,a,sel}=%b want %b", exp_q[0].tag, cyc, outv, exp_q[0].v);
          end
          void'(exp_q.pop_front());
        end
        if (!matched && cyc > 1 && outv !== prev) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_change: cycle %0d got {p,r,a,sel}=%b want %b", cyc, outv, prev);
        end
        prev = outv;
      end
    end
  end

  initial begin
    rst = 1'b1; btn_pause_i = 1'b1; btn_rst_i = 1'b1; sw_adj_i = 1'b1; sw_sel_i = 2'b11;
    push_exp(1, 1'b0, 1'b0, 1'b0, 2'b00, "reset_c1");
    push_exp(2, 1'b0, 1'b0, 1'b0, 2'b00, "reset_c2");
    push_exp(3, 1'b0, 1'b0, 1'b0, 2'b00, "post_reset");
    step(2);
    rst = 1'b0; btn_pause_i = 1'b0; btn_rst_i = 1'b0; sw_adj_i = 1'b0; sw_sel_i = 2'b00;
    step(3);

    // PAUSE press, long hold, release, second press.
    btn_pause_i = 1'b1;
    push_exp(cyc + 7, 1'b1, 1'b0, 1'b0, 2'b00, "pause_toggle_on");
    step(20);
    btn_pause_i = 1'b0;
    step(12);
    btn_pause_i = 1'b1;
    push_exp(cyc + 7, 1'b0, 1'b0, 1'b0, 2'b00, "pause_toggle_off");
    step(12);
    btn_pause_i = 1'b0;
    step(12);

    // RESET button bouncing 1,0,1,0 then held.
    btn_rst_i = 1'b1; step(1);
    btn_rst_i = 1'b0; step(1);
    btn_rst_i = 1'b1; step(1);
    btn_rst_i = 1'b0; step(1);
    btn_rst_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 7, 1'b0, 1'b1, 1'b0, 2'b00, "rst_pulse_high");
    push_exp(t0 + 8, 1'b0, 1'b0, 1'b0, 2'b00, "rst_pulse_width");
    step(12);
    btn_rst_i = 1'b0;
    step(12);

    // SEL 00->11 with bit1 lagging bit0 by two cycles, then back to 00.
    sw_sel_i = 2'b01;
    step(2);
    sw_sel_i = 2'b11;
    push_exp(cyc + 6, 1'b0, 1'b0, 1'b0, 2'b11, "sel_skewed_11");
    step(12);
    sw_sel_i = 2'b00;
    push_exp(cyc + 6, 1'b0, 1'b0, 1'b0, 2'b00, "sel_back_00");
    step(12);

    // ADJ clean change both ways.
    sw_adj_i = 1'b1;
    push_exp(cyc + 6, 1'b0, 1'b0, 1'b1, 2'b00, "adj_rise");
    step(12);
    sw_adj_i = 1'b0;
    push_exp(cyc + 6, 1'b0, 1'b0, 1'b0, 2'b00, "adj_fall");
    step(12);

    // Arm pause_o=1, then press both buttons in the same cycle.
    btn_pause_i = 1'b1;
    push_exp(cyc + 7, 1'b1, 1'b0, 1'b0, 2'b00, "pause_arm");
    step(10);
    btn_pause_i = 1'b0;
    step(12);
    btn_pause_i = 1'b1; btn_rst_i = 1'b1;
    t0 = cyc;
    push_exp(t0 + 7, 1'b0, 1'b1, 1'b0, 2'b00, "both_rst_wins");
    push_exp(t0 + 8, 1'b0, 1'b0, 1'b0, 2'b00, "both_pulse_end");
    step(12);
    btn_pause_i = 1'b0; btn_rst_i = 1'b0;
    step(12);

    // ADJ 3-cycle glitch, then a 4-cycle hold cut by reset mid-count.
    sw_adj_i = 1'b1;
    step(3);
    sw_adj_i = 1'b0;
    step(12);
    sw_adj_i = 1'b1;
    step(3);
    rst = 1'b1;
    push_exp(cyc + 1, 1'b0, 1'b0, 1'b0, 2'b00, "mid_count_reset");
    step(1);
    rst = 1'b0; sw_adj_i = 1'b0;
    push_exp(cyc + 10, 1'b0, 1'b0, 1'b0, 2'b00, "adj_after_reset");
    step(15);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
